// File: rtl/seg_display_decoder.sv
// Debounces an active-low 7-segment pattern, decodes it and presents each new value over a valid/ready handshake.
// Optional build macro SEG_DP_MASK_EN: ignore the decimal-point bit (display[7]) entirely.
module seg_display_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] display,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_num,
    output logic       out_err,
    output logic [7:0] err_count
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    // The counter holds (consecutive matching samples - 1), so a pattern seen
    // STABLE_CYCLES times is accepted when the counter reaches STABLE_CYCLES-2 before the edge.
    localparam logic [3:0] RUN_SAT = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] ACC_TH  = (STABLE_CYCLES > 1) ? 4'(STABLE_CYCLES - 2) : 4'd0;

    state_t     state, state_n;
    logic [7:0] disp_m;
    logic [7:0] sample;
    logic [3:0] run_cnt;
    logic [7:0] last_rep;
    logic       have_last;
    logic       match;
    logic       accept;
    logic       load;
    logic       clear;
    logic [7:0] dec_num;
    logic       dec_err;

`ifdef SEG_DP_MASK_EN
    assign disp_m = {1'b1, display[6:0]};
`else
    assign disp_m = display;
`endif

    assign match  = (disp_m == sample);
    assign accept = (STABLE_CYCLES == 1) || (match && (run_cnt >= ACC_TH));

    always_comb begin
        dec_err = 1'b0;
        unique case (disp_m)
            8'hC0:   dec_num = 8'd0;
            8'hF9:   dec_num = 8'd1;
            8'hA4:   dec_num = 8'd2;
            8'hB0:   dec_num = 8'd3;
            8'h99:   dec_num = 8'd4;
            8'h92:   dec_num = 8'd5;
            8'h82:   dec_num = 8'd6;
            8'hFF:   dec_num = 8'd99;
            8'hBF:   dec_num = 8'hBF;
            default: begin
                dec_num = 8'hEE;
                dec_err = 1'b1;
            end
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        clear   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && (!have_last || (disp_m != last_rep))) begin
                    load    = 1'b1;
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    clear   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sample    <= 8'hFF;
            run_cnt   <= 4'd0;
            last_rep  <= 8'h00;
            have_last <= 1'b0;
            out_valid <= 1'b0;
            out_num   <= 8'h00;
            out_err   <= 1'b0;
            err_count <= 8'h00;
        end else begin
            state  <= state_n;
            sample <= disp_m;
            if (!match)
                run_cnt <= 4'd0;
            else if (run_cnt < RUN_SAT)
                run_cnt <= run_cnt + 4'd1;

            if (load) begin
                out_valid <= 1'b1;
                out_num   <= dec_num;
                out_err   <= dec_err;
                last_rep  <= disp_m;
                have_last <= 1'b1;
                if (dec_err && (err_count != 8'hFF))
                    err_count <= err_count + 8'd1;
            end else if (clear) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_decoder.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked every cycle against a run-length reference model.
module tb_seg_display_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] display = 8'hFF;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_num;
    logic       out_err;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    seg_display_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .display(display), .out_ready(out_ready),
        .out_valid(out_valid), .out_num(out_num), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference model: length of the current run of identical samples, plus the report state.
    byte unsigned tbl [byte unsigned];
    byte unsigned m_last_sample;
    int           m_run;
    bit           m_valid, m_err, m_have;
    byte unsigned m_num, m_errc, m_last_rep;

    function automatic byte unsigned mask(input byte unsigned d);
`ifdef SEG_DP_MASK_EN
        return d | 8'h80;
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        byte unsigned d;
        if (rst) begin
            m_last_sample = 8'hFF; m_run = 1;
            m_valid = 0; m_num = 0; m_err = 0; m_errc = 0; m_have = 0; m_last_rep = 0;
            return;
        end
        d = mask(display);
        if (d == m_last_sample) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_last_sample = d;
        if (m_valid) begin
            if (out_ready) m_valid = 0;
        end else if (m_run >= S && (!m_have || d != m_last_rep)) begin
            m_valid = 1;
            m_err   = !tbl.exists(d);
            m_num   = m_err ? 8'hEE : tbl[d];
            m_have  = 1;
            m_last_rep = d;
            if (m_err && m_errc != 8'hFF) m_errc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", out_valid, m_valid);
        check("err_count", err_count, m_errc);
        if (m_valid) begin
            check("out_num", out_num, m_num);
            check("out_err", out_err, m_err);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int pulses, first, n, rep3;
        byte unsigned seen[$];
        byte unsigned pool[12];

        tbl[8'hC0] = 0;  tbl[8'hF9] = 1;  tbl[8'hA4] = 2; tbl[8'hB0] = 3;
        tbl[8'h99] = 4;  tbl[8'h92] = 5;  tbl[8'h82] = 6; tbl[8'hFF] = 99;
        tbl[8'hBF] = 8'hBF;

        // Reset state
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_num", out_num, 8'h00);
        check("rst_err", out_err, 0);
        check("rst_errc", err_count, 8'h00);

        // 0xC0 held, ready high: single pulse, first after the 4th sample edge
        display = 8'hC0; out_ready = 1'b1;
        pulses = 0; first = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (out_valid) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        check("c0_pulses", pulses, 1);
        check("c0_first", first, S);

        // 0x92 held, consumer stalls 10 cycles
        display = 8'h92; out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check("92_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("92_hold_num", out_num, 8'd5);
            check("92_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        check("92_cleared", out_valid, 0);

        // 0xA4 too short, then 0xB0 held: only 3 reported
        display = 8'hA4;
        rep3 = 0; pulses = 0;
        for (int i = 0; i < 3; i++) begin step(); if (out_valid) pulses++; end
        display = 8'hB0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) begin
                pulses++;
                if (out_num == 8'd3) rep3++;
            end
        end
        check("a4b0_pulses", pulses, 1);
        check("a4b0_rep3", rep3, 1);

        // Blank, hyphen, invalid
        do_reset();
        out_ready = 1'b1;
        seen.delete();
        foreach (pool[i]) pool[i] = 8'h00;
        pool[0] = 8'hFF; pool[1] = 8'hBF; pool[2] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            display = pool[k];
            for (int i = 0; i < 6; i++) begin
                step();
                if (out_valid) begin
                    seen.push_back(out_num);
                    check("seq_err", out_err, (k == 2));
                end
            end
        end
        check("seq_len", seen.size(), 3);
        if (seen.size() == 3) begin
            check("seq_0", seen[0], 8'd99);
            check("seq_1", seen[1], 8'hBF);
            check("seq_2", seen[2], 8'hEE);
        end
        check("seq_errc", err_count, 8'd1);

        // Reset during PRESENT, then re-report 4 edges after release
        display = 8'hC0; out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check("rp_valid", out_valid, 1);
        out_ready = 1'b1;
        do_reset();
        check("rp_rst_valid", out_valid, 0);
        check("rp_rst_errc", err_count, 8'd0);
        n = 0;
        while (!out_valid && n < 10) begin step(); n++; end
        check("rp_latency", n, S);
        check("rp_num", out_num, 8'd0);

        // Decimal point low
        do_reset();
        display = 8'h40;
        n = 0;
        while (!out_valid && n < 10) begin step(); n++; end
`ifdef SEG_DP_MASK_EN
        check("dp_num", out_num, 8'd0);
        check("dp_err", out_err, 0);
        check("dp_errc", err_count, 8'd0);
`else
        check("dp_num", out_num, 8'hEE);
        check("dp_err", out_err, 1);
        check("dp_errc", err_count, 8'd1);
`endif

        // err_count saturation: alternate two invalid patterns
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 262; k++) begin
            display = (k % 2 == 0) ? 8'h01 : 8'h02;
            for (int i = 0; i < S + 1; i++) step();
        end
        check("errc_sat", err_count, 8'hFF);

        // Randomized traffic
        do_reset();
        pool = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hFF, 8'hBF, 8'h40, 8'h00, 8'h12};
        for (int t = 0; t < 600; t++) begin
            n = $urandom_range(0, 12);
            display = (n == 12) ? 8'($urandom) : pool[n];
            for (int i = $urandom_range(1, 7); i > 0; i--) begin
                out_ready = 1'($urandom);
                rst = ($urandom_range(0, 199) == 0);
                step();
            end
            rst = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_decoder.md
SEG_DISPLAY_DECODER -- requirements
Module: seg_display_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, legal range 1..15: number of consecutive identical samples required before a pattern is accepted.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port display, input, 8 bits: active-low segment pattern, bit 7 = decimal point, bits 6..0 = segments g..a.
REQ-005 The block SHALL have port out_ready, input, 1 bit: consumer accepts the presented value.
REQ-006 The block SHALL have port out_valid, output, 1 bit: a decoded value is presented.
REQ-007 The block SHALL have port out_num, output, 8 bits: decoded value.
REQ-008 The block SHALL have port out_err, output, 1 bit: the presented pattern was not in the code table.
REQ-009 The block SHALL have port err_count, output, 8 bits: number of invalid patterns accepted, saturating.

Function
REQ-010 display SHALL be registered every cycle into a sample register; a 4-bit run counter SHALL clear when display differs from the sample register and otherwise increment, saturating at STABLE_CYCLES-1.
REQ-011 A pattern P SHALL be accepted on the edge where P has been sampled on STABLE_CYCLES consecutive edges (STABLE_CYCLES=1: every edge).
REQ-012 Decode table: 0xC0->0, 0xF9->1, 0xA4->2, 0xB0->3, 0x99->4, 0x92->5, 0x82->6, 0xFF->99 (blank), 0xBF->0xBF (hyphen); any other pattern -> out_num 0xEE with out_err=1.
REQ-013 FSM states SHALL be IDLE and PRESENT.
REQ-014 In IDLE, an accepted pattern different from last_reported (or any accepted pattern when no report has been made since reset) SHALL on the same edge load out_num/out_err, set out_valid=1, store last_reported=P and enter PRESENT.
REQ-015 An accepted pattern equal to last_reported SHALL NOT produce a new report.
REQ-016 In PRESENT, out_valid, out_num and out_err SHALL remain constant until a cycle with out_valid=1 and out_ready=1; on that edge out_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-017 Sampling and run counting SHALL continue during PRESENT; a pattern stabilising during PRESENT SHALL be reported from IDLE on the first edge after the handshake on which it is still accepted and differs from last_reported.
REQ-018 Latency: display held at P from edge k with IDLE and P new SHALL give out_valid=1 after edge k+STABLE_CYCLES-1.
REQ-019 err_count SHALL increment by 1 on each report with out_err=1 and SHALL saturate at 255.
REQ-020 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-021 While rst=1 on an edge: out_valid=0, out_num=0x00, out_err=0, err_count=0, FSM=IDLE, run counter=0, sample register=0xFF, last-reported flag cleared.
REQ-022 rst SHALL override all other events on the same edge, including a pending handshake; a pattern held across reset SHALL be re-reported after STABLE_CYCLES post-reset samples.

Configuration
REQ-023 With macro SEG_DP_MASK_EN defined, display bit 7 SHALL be forced to 1 before sampling, comparison and decode, so the decimal point state is ignored.
REQ-024 Without SEG_DP_MASK_EN, bit 7 SHALL be used as received; a pattern with bit 7=0 SHALL decode as invalid (0xEE, out_err=1).

Verification
REQ-025 STABLE_CYCLES=4, out_ready=1, display=0xC0 held after reset -> one out_valid pulse with out_num=0, out_err=0, first high after the 4th sample edge; no further pulses.
REQ-026 display=0x92 held, out_ready=0 for 10 cycles then 1 for one cycle -> out_valid high with out_num=5 throughout, cleared the cycle after the ready cycle.
REQ-027 display=0xA4 for 3 cycles then 0xB0 held -> no report of 2; single report of out_num=3.
REQ-028 Sequence 0xFF, 0xBF, 0x00 each held 6 cycles, out_ready=1 -> out_num 99, 0xBF, 0xEE; out_err only on the third; err_count=1.
REQ-029 rst asserted one cycle during PRESENT with display held -> out_valid=0 and err_count=0 after the reset edge; same value reported again 4 edges after reset release.
REQ-030 display=0x40 held -> with SEG_DP_MASK_EN out_num=0, out_err=0; without it out_num=0xEE, out_err=1, err_count=1.
